// File: rtl/ttc_pattern_gen_pkg.sv
// Shared definitions for the TTC pattern generator and the BER checker.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package ttc_pkg;

    // Run-time pattern selection, matches the 2-bit mode input encoding.
    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_PRBS   = 2'd1,
        MODE_ALT    = 2'd2,
        MODE_FRAMED = 2'd3
    } ttc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } ttc_state_e;

    // PRBS-15 (x^15 + x^14 + 1): output is the MSB, feedback XORs the two top taps.
    localparam logic [14:0] PRBS15_SEED   = 15'h7FFF;
    localparam int          PRBS15_TAP_HI = 14;
    localparam int          PRBS15_TAP_LO = 13;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ttc_pattern_gen_if.sv
// Control/data bundle between the TTC pattern generator and its user.
// Latency: n/a (wiring only).
// Backpressure: none; bit_tick paces the serial stream, no ready path.
// master: drives en, bit_tick, mode, word_in, word_load, err_inj; samples outputs.
// slave : the generator; drives out, out_valid, frame_start, busy.
interface ttc_pattern_gen_if #(
    parameter int WORD_W = 32
);
    logic              en;
    logic              bit_tick;
    logic [1:0]        mode;
    logic [WORD_W-1:0] word_in;
    logic              word_load;
    logic              err_inj;
    logic              out;
    logic              out_valid;
    logic              frame_start;
    logic              busy;

    modport master (
        output en, bit_tick, mode, word_in, word_load, err_inj,
        input  out, out_valid, frame_start, busy
    );

    modport slave (
        input  en, bit_tick, mode, word_in, word_load, err_inj,
        output out, out_valid, frame_start, busy
    );
endinterface

// File: rtl/ttc_pattern_gen_prbs15.sv
// PRBS-15 generator with synchronous seed load and advance enable.
// Latency: bit_o is the current register MSB; advances one step per adv_i clock.
// Backpressure: none; holds state while adv_i is low. load_i has priority.
// Ports: clk, rst (async, active-low), load_i, adv_i, bit_o.
module ttc_prbs15
    import ttc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic adv_i,
    output logic bit_o
);

    logic [14:0] lfsr_q;
    logic [14:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = PRBS15_SEED;
        end else if (adv_i) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[PRBS15_TAP_HI] ^ lfsr_q[PRBS15_TAP_LO]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= PRBS15_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[PRBS15_TAP_HI];

endmodule

// File: rtl/ttc_pattern_gen.sv
// Serial test-pattern generator: fixed word, PRBS-15, alternating, or sync+PRBS frames.
// Latency: one clk from a bit_tick to the bit on out; out holds between ticks.
// Backpressure: none; one bit per bit_tick, en low aborts to IDLE on the next edge.
// Ports: clk, rst (async, active-low), bus (ttc_pattern_gen_if.slave).
module ttc_pattern_gen
    import ttc_pkg::*;
#(
    parameter int                WORD_W       = 32,
    parameter logic [WORD_W-1:0] DEFAULT_WORD = WORD_W'(32'hA18D9534),
    parameter bit                MSB_FIRST    = 1'b0,
    parameter int                SYNC_W       = 32,
    parameter logic [SYNC_W-1:0] SYNC_WORD    = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter int                FRAME_BITS   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ttc_pattern_gen_if.slave  bus
);

    // One counter serves word position, sync position and payload position.
    localparam int               CNT_W      = $clog2(max3(WORD_W, SYNC_W, FRAME_BITS));
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    ttc_state_e        state_q, state_d;
    ttc_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic              err_pend_q, err_pend_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_start_q, frame_start_d;

    ttc_mode_e         new_mode;
    logic [CNT_W-1:0]  word_idx;
    logic [CNT_W-1:0]  sync_idx;
    logic              word_bit;
    logic              sync_bit;
    logic              prbs_bit;
    logic              prbs_load;
    logic              prbs_adv;
    logic              cur_bit;
    logic              emit;
    logic              first_bit;
    logic              boundary;
    logic              reenter;

    ttc_prbs15 u_prbs (
        .clk    (clk),
        .rst    (rst),
        .load_i (prbs_load),
        .adv_i  (prbs_adv),
        .bit_o  (prbs_bit)
    );

    assign new_mode = ttc_mode_e'(bus.mode);
    assign word_idx = MSB_FIRST ? (WORD_LAST - cnt_q) : cnt_q;
    assign sync_idx = SYNC_LAST - cnt_q;   // marker always goes MSB first

    always_comb begin
        word_bit = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (word_idx == CNT_W'(i)) word_bit = word_q[i];
        end
        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (sync_idx == CNT_W'(i)) sync_bit = SYNC_WORD[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        shadow_d      = bus.word_load ? bus.word_in : shadow_q;
        err_pend_d    = err_pend_q | bus.err_inj;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        frame_start_d = 1'b0;
        prbs_load     = 1'b0;
        prbs_adv      = 1'b0;
        cur_bit       = 1'b0;
        emit          = 1'b0;
        first_bit     = 1'b0;
        boundary      = 1'b0;
        reenter       = 1'b0;

        if (state_q == ST_IDLE) begin
            reenter = bus.en;
        end else if (!bus.en) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (bus.bit_tick) begin
            emit  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (state_q == ST_SYNC) begin
                cur_bit   = sync_bit;
                first_bit = (cnt_q == '0);
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end else begin
                case (mode_q)
                    MODE_FIXED: begin
                        cur_bit   = word_bit;
                        first_bit = (cnt_q == '0);
                        if (cnt_q == WORD_LAST) begin
                            cnt_d    = '0;
                            word_d   = shadow_q;   // a load on this very tick waits a word
                            boundary = 1'b1;
                        end
                    end
                    MODE_PRBS: begin
                        cur_bit  = prbs_bit;
                        prbs_adv = 1'b1;
                        boundary = 1'b1;
                    end
                    MODE_ALT: begin
                        // Counter wraps modulo a power of two, so parity stays correct.
                        cur_bit  = ~cnt_q[0];
                        boundary = 1'b1;
                    end
                    default: begin
                        cur_bit  = prbs_bit;
                        prbs_adv = 1'b1;   // LFSR runs on across frames
                        if (cnt_q == FRAME_LAST) begin
                            cnt_d    = '0;
                            state_d  = ST_SYNC;
                            boundary = 1'b1;
                        end
                    end
                endcase
            end
            reenter = boundary && (new_mode != mode_q);
        end

        if (emit) begin
            out_d         = cur_bit ^ (err_pend_q | bus.err_inj);
            out_valid_d   = 1'b1;
            frame_start_d = first_bit;
            err_pend_d    = 1'b0;
        end

        // Same restart whether leaving IDLE or switching mode at a boundary.
        if (reenter) begin
            mode_d    = new_mode;
            cnt_d     = '0;
            prbs_load = 1'b1;
            state_d   = (new_mode == MODE_FRAMED) ? ST_SYNC : ST_PAYLOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_FIXED;
            cnt_q         <= '0;
            word_q        <= DEFAULT_WORD;
            shadow_q      <= DEFAULT_WORD;
            err_pend_q    <= 1'b0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            shadow_q      <= shadow_d;
            err_pend_q    <= err_pend_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ttc_pattern_gen.sv
// Directed bench for ttc_pattern_gen: fixed, word reload, alternating with error
// injection, PRBS-15, framed with restart, and asynchronous reset.
// Ticks are one clk wide every 4 clks; outputs are sampled on the falling edge.
module tb_ttc_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ttc_pattern_gen_if #(.WORD_W(32)) bus_if ();

    ttc_pattern_gen #(
        .WORD_W       (32),
        .DEFAULT_WORD (32'hA18D9534),
        .MSB_FIRST    (1'b0),
        .SYNC_W       (32),
        .SYNC_WORD    (32'h1ACFFC1D),
        .FRAME_BITS   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Hand-derived reference patterns.
    logic [31:0] w0;     // reset word, sent LSB first
    logic [31:0] w1;     // reloaded word
    logic [31:0] sync;   // marker, MSB first
    logic [31:0] prbs;   // first 32 PRBS-15 bits from seed 7FFF, first bit at [31]
    logic [7:0]  w0_lo;  // first 8 bits of w0 in send order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input logic exp_out, input logic exp_fs,
                        input logic inj);
        @(negedge clk);
        bus_if.bit_tick = 1'b1;
        bus_if.err_inj  = inj;
        @(negedge clk);
        bus_if.bit_tick = 1'b0;
        bus_if.err_inj  = 1'b0;
        check({tag, "_out"}, 32'(bus_if.out), 32'(exp_out));
        check({tag, "_vld"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_fs"},  32'(bus_if.frame_start), 32'(exp_fs));
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_err();
        @(negedge clk);
        bus_if.err_inj = 1'b1;
        @(negedge clk);
        bus_if.err_inj = 1'b0;
    endtask

    task automatic start(input logic [1:0] m);
        bus_if.mode = m;
        bus_if.en   = 1'b1;
        @(negedge clk);
        check($sformatf("start%0d_busy", m), 32'(bus_if.busy), 32'd1);
        check($sformatf("start%0d_vld", m),  32'(bus_if.out_valid), 32'd0);
    endtask

    task automatic stop(input string tag, input logic exp_out);
        bus_if.en = 1'b0;
        @(negedge clk);
        check({tag, "_vld"},  32'(bus_if.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_hold"}, 32'(bus_if.out), 32'(exp_out));
    endtask

    initial begin
        w0    = 32'hA18D9534;
        w1    = 32'hFFFF0000;
        sync  = 32'h1ACFFC1D;
        prbs  = 32'hFFFE0004;
        w0_lo = 8'b0011_0100;

        bus_if.en        = 1'b0;
        bus_if.bit_tick  = 1'b0;
        bus_if.mode      = 2'd0;
        bus_if.word_in   = '0;
        bus_if.word_load = 1'b0;
        bus_if.err_inj   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out",  32'(bus_if.out), 32'd0);
        check("rst_vld",  32'(bus_if.out_valid), 32'd0);
        check("rst_fs",   32'(bus_if.frame_start), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fixed word, LSB first: 0x34 gives 0,0,1,0,1,1,0,0
        start(2'd0);
        for (int i = 0; i < 32; i++)
            tick($sformatf("fix1_%0d", i), (i < 8) ? w0_lo[i] : w0[i], i == 0, 1'b0);
        // Second word repeats; reload mid-word must not disturb it
        for (int i = 0; i < 5; i++)
            tick($sformatf("fix2_%0d", i), w0[i], i == 0, 1'b0);
        @(negedge clk);
        bus_if.word_in   = w1;
        bus_if.word_load = 1'b1;
        @(negedge clk);
        bus_if.word_load = 1'b0;
        bus_if.word_in   = '0;
        for (int i = 5; i < 32; i++)
            tick($sformatf("fix2_%0d", i), w0[i], 1'b0, 1'b0);
        // Third word is the reloaded one: 16 zeros then 16 ones
        for (int i = 0; i < 32; i++)
            tick($sformatf("fix3_%0d", i), w1[i], i == 0, 1'b0);
        stop("fix_stop", 1'b1);

        // Alternating with error injection
        start(2'd2);
        tick("alt1", 1'b1, 1'b0, 1'b0);
        tick("alt2", 1'b0, 1'b0, 1'b0);
        tick("alt3", 1'b1, 1'b0, 1'b0);
        pulse_err();
        tick("alt4_err", 1'b1, 1'b0, 1'b0);
        tick("alt5", 1'b1, 1'b0, 1'b0);
        tick("alt6", 1'b0, 1'b0, 1'b0);
        tick("alt7_coinc", 1'b0, 1'b0, 1'b1);
        tick("alt8", 1'b0, 1'b0, 1'b0);
        pulse_err();
        pulse_err();
        tick("alt9_dbl", 1'b0, 1'b0, 1'b0);
        tick("alt10", 1'b0, 1'b0, 1'b0);
        stop("alt_stop", 1'b0);

        // Tick while idle is ignored
        @(negedge clk);
        bus_if.bit_tick = 1'b1;
        @(negedge clk);
        bus_if.bit_tick = 1'b0;
        check("idle_tick_vld", 32'(bus_if.out_valid), 32'd0);
        check("idle_tick_out", 32'(bus_if.out), 32'd0);

        // PRBS-15: fifteen ones, then zeros
        start(2'd1);
        for (int i = 0; i < 32; i++)
            tick($sformatf("prbs_%0d", i), prbs[31-i], 1'b0, 1'b0);
        stop("prbs_stop", prbs[0]);

        // Framed: sync, payload, sync, continued payload
        start(2'd3);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 32; i++)
                tick($sformatf("fr%0d_sync_%0d", f, i), sync[31-i], i == 0, 1'b0);
            for (int i = 0; i < 16; i++)
                tick($sformatf("fr%0d_pay_%0d", f, i), prbs[31-(16*f+i)], 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++)
            tick($sformatf("fr2_sync_%0d", i), sync[31-i], i == 0, 1'b0);
        stop("fr_abort", sync[27]);

        // Restart: full marker and a reseeded LFSR
        start(2'd3);
        for (int i = 0; i < 32; i++)
            tick($sformatf("rs_sync_%0d", i), sync[31-i], i == 0, 1'b0);
        for (int i = 0; i < 3; i++)
            tick($sformatf("rs_pay_%0d", i), prbs[31-i], 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out",  32'(bus_if.out), 32'd0);
        check("arst_vld",  32'(bus_if.out_valid), 32'd0);
        check("arst_busy", 32'(bus_if.busy), 32'd0);
        check("arst_fs",   32'(bus_if.frame_start), 32'd0);
        bus_if.en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
